ibexc_tsmap_mem: RTL
====================

IBEXC_TSMAP_MEM -- requirements
Module: ibexc_tsmap_mem

Interface
REQ-001 Parameter TSMapSize, default 1024, number of 32-bit revocation-bitmap words held (legal 2..65536).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 tsmap_cs_i  input  1  core bitmap read strobe (driven by core tsmap_cs_o).
REQ-005 tsmap_addr_i  input  16  core word address.
REQ-006 tsmap_rdata_o  output  32  core read data, registered.
REQ-007 host_req_i  input  1  revoker/bus access request.
REQ-008 host_we_i  input  1  1 = write, 0 = read.
REQ-009 host_addr_i  input  16  host word address.
REQ-010 host_be_i  input  4  host write byte enables.
REQ-011 host_wdata_i  input  32  host write data.
REQ-012 host_gnt_o  output  1  host request accepted this cycle.
REQ-013 host_rvalid_o  output  1  host response valid.
REQ-014 host_rdata_o  output  32  host read data.
REQ-015 host_err_o  output  1  host response error, qualified by host_rvalid_o.
REQ-016 clr_req_i  input  1  start bulk clear of whole map.
REQ-017 busy_o  output  1  clear sequence in progress.

Function
REQ-018 Storage SHALL be TSMapSize x 32 flops, not reset; contents defined only by the clear sequence and host writes.
REQ-019 FSM SHALL have exactly two states, CLEAR and IDLE; busy_o SHALL be 1 iff state is CLEAR.
REQ-020 CLEAR: each cycle word[ptr] <= 0 and ptr increments; in the cycle word TSMapSize-1 is written, the next state SHALL be IDLE, i.e. CLEAR lasts exactly TSMapSize cycles.
REQ-021 IDLE with clr_req_i=1 SHALL move to CLEAR next cycle with ptr=0; clr_req_i in CLEAR SHALL be ignored (no restart).
REQ-022 Core read: tsmap_cs_i=1 in cycle N SHALL present word[tsmap_addr_i] on tsmap_rdata_o in cycle N+1; without cs, tsmap_rdata_o SHALL hold its previous value.
REQ-023 Core read with tsmap_addr_i >= TSMapSize, or issued while in CLEAR, SHALL return 0.
REQ-024 host_gnt_o SHALL = host_req_i & IDLE & ~tsmap_cs_i & ~clr_req_i (core and clear have priority; host waits, request held until granted).
REQ-025 Granted access in cycle N SHALL give host_rvalid_o=1 for exactly cycle N+1; at most one outstanding host access.
REQ-026 Granted write SHALL update only bytes with host_be_i set, effective at end of cycle N; host_rdata_o=0 on write responses.
REQ-027 Granted read SHALL return word[host_addr_i] as sampled in cycle N on host_rdata_o in N+1.
REQ-028 host_addr_i >= TSMapSize SHALL give host_err_o=1, host_rdata_o=0, and no storage change.
REQ-029 Core read at cycle N+1 of a word host-written in cycle N SHALL return the new value (no bypass needed; write is committed first).
REQ-030 host_err_o and host_rdata_o SHALL be 0 whenever host_rvalid_o=0.

Reset
REQ-031 rst_ni=0 at a clock edge SHALL set state=CLEAR, ptr=0, tsmap_rdata_o=0, host_rvalid_o=0, host_err_o=0, host_rdata_o=0; busy_o=1 from the following cycle.
REQ-032 Reset asserted mid-CLEAR or mid-host-access SHALL restart CLEAR from ptr=0 and drop any pending response.
REQ-033 After reset release, map SHALL read all-zero once busy_o falls.

Verification
REQ-034 Reset with TSMapSize=1024 -> busy_o=1 for exactly 1024 cycles after release, then 0; core reads of addr 0, 511, 1023 return 0.
REQ-035 Host write addr 5, be=4'b0101, wdata=32'hAABBCCDD after clear -> next-cycle rvalid, err=0; core read addr 5 returns 32'h00BB00DD.
REQ-036 host_req_i and tsmap_cs_i both high for 3 cycles -> host_gnt_o=0 those cycles, core reads return data each next cycle, host granted first cycle cs drops.
REQ-037 Host read addr 16'h0400 (TSMapSize=1024) -> rvalid with host_err_o=1, host_rdata_o=0; core read addr 16'h0400 returns 0.
REQ-038 Write 32'hFFFFFFFF to addr 7, pulse clr_req_i with simultaneous host_req_i -> no grant, busy_o=1 for 1024 cycles, addr 7 then reads 0; second clr_req_i mid-clear does not extend busy.
REQ-039 rst_ni low for one cycle at clear cycle 300 -> busy_o remains 1 for a full 1024 cycles after release.

Source files
------------

// File: rtl/ibexc_tsmap_mem_if.sv
// Host (revoker/bus) access port of the temporal-safety revocation map.
// The slave side is the map; the master side is whoever issues accesses.
interface ibexc_tsmap_mem_if;
  logic        host_req_i;
  logic        host_we_i;
  logic [15:0] host_addr_i;
  logic [3:0]  host_be_i;
  logic [31:0] host_wdata_i;
  logic        host_gnt_o;
  logic        host_rvalid_o;
  logic [31:0] host_rdata_o;
  logic        host_err_o;

  modport master (
    output host_req_i, host_we_i, host_addr_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o
  );

  modport slave (
    input  host_req_i, host_we_i, host_addr_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o
  );
endinterface

// File: rtl/ibexc_tsmap_mem.sv
// Revocation bitmap storage. The core has a read-only port with top priority,
// a host port does byte-masked reads/writes when the core is quiet, and a
// bulk clear sweeps the whole map to zero after reset or on request.
module ibexc_tsmap_mem #(
  parameter int unsigned TSMapSize = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     tsmap_cs_i,
  input  logic [15:0]              tsmap_addr_i,
  output logic [31:0]              tsmap_rdata_o,
  ibexc_tsmap_mem_if.slave         host,
  input  logic                     clr_req_i,
  output logic                     busy_o
);

  localparam int unsigned PW = (TSMapSize > 1) ? $clog2(TSMapSize) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   ptr_q;
  logic [31:0]     mem_q [TSMapSize];

  logic            core_inr;
  logic            host_inr;
  logic            gnt;
  logic            host_wr;

  // Addresses are compared one bit wider so TSMapSize=65536 works.
  assign core_inr = {1'b0, tsmap_addr_i} < 17'(TSMapSize);
  assign host_inr = {1'b0, host.host_addr_i} < 17'(TSMapSize);

  // Core and clear both win over the host; the host simply holds its request.
  assign gnt             = host.host_req_i & (state_q == IDLE) & ~tsmap_cs_i & ~clr_req_i;
  assign host.host_gnt_o = gnt;
  // A write that coincides with reset is dropped; the clear would wipe it anyway.
  assign host_wr         = gnt & host.host_we_i & host_inr & rst_ni;

  // Storage: clear sweep writes zero, otherwise granted host writes per byte lane.
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else if (host_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (host.host_be_i[b]) begin
          mem_q[host.host_addr_i[PW-1:0]][8*b +: 8] <= host.host_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Clear FSM; busy_o is registered alongside the state so it never glitches.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_o  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == PW'(TSMapSize - 1)) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          if (clr_req_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_o  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Core read port: one-cycle latency, holds between strobes, zero while clearing.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tsmap_rdata_o <= '0;
    end else if (tsmap_cs_i) begin
      tsmap_rdata_o <= (state_q == CLEAR || !core_inr) ? 32'h0 : mem_q[tsmap_addr_i[PW-1:0]];
    end
  end

  // Host response: single-cycle valid, data and error forced to zero when not valid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      host.host_rvalid_o <= 1'b0;
      host.host_err_o    <= 1'b0;
      host.host_rdata_o  <= '0;
    end else begin
      host.host_rvalid_o <= gnt;
      host.host_err_o    <= gnt & ~host_inr;
      host.host_rdata_o  <= (gnt && !host.host_we_i && host_inr) ?
                            mem_q[host.host_addr_i[PW-1:0]] : 32'h0;
    end
  end

endmodule
